dispatch_demux: RTL and testbench
=================================

// Module: dispatch_demux
// PURPOSE
//  Inverse of the operand/result select muxes: steers one 32-bit stream to one of N
//  destination lanes (execution-unit issue slots) by a select code, buffering each lane
//  in its own small FIFO. Sits between decode and the per-unit issue logic. Valid/ready
//  handshakes on both sides; a flush input empties all lanes on a redirect.
// PARAMETERS
//  DATA_W     32  width of each routed word
//  NUM_PORTS  4   number of destination lanes, legal range 2..4
//  SEL_W      2   select width; fixed, covers NUM_PORTS<=4
//  DEPTH      4   entries per lane FIFO, power of two, >=2
// PORTS
//  clk        in   1                 single clock, all state on rising edge
//  reset      in   1                 asynchronous, active-high; clears all state
//  flush      in   1                 synchronous clear of every lane FIFO
//  in_valid   in   1                 upstream word present
//  in_ready   out  1                 block accepts word this cycle
//  in_data    in   DATA_W            word to route
//  in_select  in   SEL_W             destination lane index
//  out_valid  out  NUM_PORTS         lane i has a word at its head
//  out_ready  in   NUM_PORTS         lane i consumer takes head word
//  out_data   out  NUM_PORTS*DATA_W  lane i head word at [i*DATA_W +: DATA_W]
//  drop_err   out  1                 one-cycle pulse: word with illegal select dropped
//  idle       out  1                 all lanes empty
// BEHAVIOUR
//  - Reset (async assert): all read/write pointers 0; out_valid=0; out_data=0; drop_err=0;
//    idle=1; in_ready=1 once reset deasserts. Storage array itself is not reset.
//  - in_ready (combinational) = !flush && (in_select>=NUM_PORTS || !full[in_select]).
//    No pass-through: a pop from a full lane does not raise in_ready in that same cycle.
//  - Push: in_valid&&in_ready&&in_select<NUM_PORTS -> write lane in_select, wptr+1.
//  - Latency: word accepted in cycle T appears at out_valid/out_data in T+1 (registered).
//  - Pop: out_valid[i]&&out_ready[i] -> rptr[i]+1 at the edge; lanes pop independently,
//    any subset in one cycle. out_ready on an empty lane is ignored.
//  - Same-lane push+pop in one cycle: both happen, occupancy unchanged. Push into an
//    empty lane while its consumer asserts out_ready: push only, word visible next cycle.
//  - out_data lane i = head entry when out_valid[i]=1, else forced 0.
//  - Pointers are log2(DEPTH)+1 bits; wrap naturally; full = MSBs differ & LSBs equal;
//    empty = pointers equal. Lane holds exactly DEPTH words when full.
//  - Illegal select (>=NUM_PORTS, only when NUM_PORTS<4): handshake completes
//    (in_ready=1), word discarded, drop_err=1 next cycle for one cycle. Never writes a lane.
//  - flush: at the edge all rptr:=wptr (lanes empty); pops and pushes that cycle are
//    suppressed; in_ready=0 while flush=1; out_valid=0 from the next cycle.
//  - Reset asserted mid-transfer: state cleared immediately, in-flight words lost.
//  - idle = all lanes empty (registered-state derived, no combinational input path).
//  - No state machine beyond per-lane pointer counters; lanes are fully independent.
// STRUCTURE
//  - Shared package: DATA_W default, SEL_W, lane-count limit, and lane index constants
//    shared with the issue logic.
//  - One sub-module: dispatch_lane_fifo (DATA_W, DEPTH; push, pop, flush, full, empty,
//    head). dispatch_demux = select decode + ready mux + drop_err reg + NUM_PORTS lanes.
// TESTING
//  1 Reset: assert reset mid-run -> out_valid=0, idle=1, drop_err=0 same cycle; in_ready=1 after.
//  2 Route: push 0xA0..0xA3 with select 0..3, out_ready=0 -> next cycle out_valid=4'b1111,
//    lane i data=0xA0+i; pop all -> idle=1.
//  3 Full: 4 pushes select=2, out_ready=0 -> in_ready=0 when select=2, still 1 for select=0;
//    one pop lane 2 -> in_ready=1 next cycle; order 1st-in first-out preserved.
//  4 Concurrency: lane 1 holds 2 words, push+pop lane 1 same cycle -> count stays 2;
//    wrap pointers 3x DEPTH, data order intact.
//  5 Flush: lanes 0,3 non-empty, flush with in_valid=1 -> in_ready=0, next cycle
//    out_valid=0, idle=1, flushed word not stored.
//  6 NUM_PORTS=3: push select=3 data 0xDEAD -> in_ready=1, drop_err pulses 1 cycle,
//    no lane out_valid rises.

Source files
------------

// File: rtl/dispatch_demux_pkg.sv
// Shared constants for the decode-to-issue dispatch demux and the issue logic behind it.
// Lane indices name the execution-unit issue slots fed by each demux output.
package dispatch_demux_pkg;

  localparam int DD_DATA_W    = 32;
  localparam int DD_SEL_W     = 2;
  localparam int DD_MAX_PORTS = 4;
  localparam int DD_DEPTH     = 4;

  localparam logic [DD_SEL_W-1:0] LANE_ALU0 = 2'd0;
  localparam logic [DD_SEL_W-1:0] LANE_ALU1 = 2'd1;
  localparam logic [DD_SEL_W-1:0] LANE_LSU  = 2'd2;
  localparam logic [DD_SEL_W-1:0] LANE_BRU  = 2'd3;

  // A select code is routable only when it names a lane that is actually built.
  function automatic logic dd_sel_legal(input logic [DD_SEL_W-1:0] sel, input int num_ports);
    return int'(sel) < num_ports;
  endfunction

endpackage

// File: rtl/dispatch_demux_if.sv
// Upstream and per-lane downstream valid/ready bundle of the dispatch demux.
// The master side is decode plus the issue consumers; the slave side is the demux.
interface dispatch_demux_if
  import dispatch_demux_pkg::*;
#(
  parameter int DATA_W    = DD_DATA_W,
  parameter int NUM_PORTS = DD_MAX_PORTS,
  parameter int SEL_W     = DD_SEL_W
);

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic [SEL_W-1:0]              in_select;
  logic [NUM_PORTS-1:0]          out_valid;
  logic [NUM_PORTS-1:0]          out_ready;
  logic [NUM_PORTS*DATA_W-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_select, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_select, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dispatch_demux_lane_fifo.sv
// One destination lane: a DEPTH-entry FIFO with extended pointers and a synchronous flush.
// The storage array is deliberately left out of reset; only the pointers define contents.
module dispatch_lane_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rptr[AW-1:0]];

  // Flush discards everything queued by catching the read pointer up to the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dispatch_demux.sv
// Steers one decoded word to an issue-slot lane by select code, one FIFO per lane.
// Words with a select naming a lane that is not built are accepted and dropped.
module dispatch_demux
  import dispatch_demux_pkg::*;
#(
  parameter int DATA_W    = DD_DATA_W,
  parameter int NUM_PORTS = DD_MAX_PORTS,
  parameter int SEL_W     = DD_SEL_W,
  parameter int DEPTH     = DD_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  dispatch_demux_if.slave    bus,
  output logic               drop_err,
  output logic               idle
);

  logic [NUM_PORTS-1:0]        full;
  logic [NUM_PORTS-1:0]        empty;
  logic [NUM_PORTS-1:0]        push;
  logic [DATA_W-1:0]           head [NUM_PORTS];
  logic [NUM_PORTS*DATA_W-1:0] out_data_c;
  logic                        sel_legal;
  logic                        sel_full;
  logic                        accept;

  assign sel_legal = dd_sel_legal(bus.in_select, NUM_PORTS);

  // Ready looks only at the registered full flag, so a same-cycle pop never frees a slot early.
  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (bus.in_select == SEL_W'(i)) sel_full = full[i];
    end
  end

  assign bus.in_ready = !flush && (!sel_legal || !sel_full);
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    assign push[g] = accept && sel_legal && (bus.in_select == SEL_W'(g));

    dispatch_lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .push   (push[g]),
      .pop    (bus.out_ready[g]),
      .wdata  (bus.in_data),
      .full   (full[g]),
      .empty  (empty[g]),
      .head   (head[g])
    );
  end

  always_comb begin
    out_data_c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      out_data_c[i*DATA_W +: DATA_W] = empty[i] ? '0 : head[i];
    end
  end

  assign bus.out_data  = out_data_c;
  assign bus.out_valid = ~empty;
  assign idle          = &empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_err <= 1'b0;
    else       drop_err <= accept && !sel_legal;
  end

endmodule

// File: tb/tb_dispatch_demux.sv
// Bench for dispatch_demux: a 4-lane and a 3-lane instance share stimulus; a queue model
// predicts both, plus a hand-computed vector table and directed corner sequences.
module tb_dispatch_demux;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic v_flush;
  logic v_valid;
  logic [1:0] v_sel;
  logic [31:0] v_data;
  logic [3:0] v_ordy;

  logic drop4, idle4, drop3, idle3;

  dispatch_demux_if #(.DATA_W(DW), .NUM_PORTS(4), .SEL_W(2)) bus4 ();
  dispatch_demux_if #(.DATA_W(DW), .NUM_PORTS(3), .SEL_W(2)) bus3 ();

  assign bus4.in_valid  = v_valid;
  assign bus4.in_select = v_sel;
  assign bus4.in_data   = v_data;
  assign bus4.out_ready = v_ordy;
  assign bus3.in_valid  = v_valid;
  assign bus3.in_select = v_sel;
  assign bus3.in_data   = v_data;
  assign bus3.out_ready = v_ordy[2:0];

  dispatch_demux #(.DATA_W(DW), .NUM_PORTS(4), .SEL_W(2), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .reset(reset), .flush(v_flush), .bus(bus4.slave), .drop_err(drop4), .idle(idle4)
  );

  dispatch_demux #(.DATA_W(DW), .NUM_PORTS(3), .SEL_W(2), .DEPTH(DEPTH)) dut3 (
    .clk(clk), .reset(reset), .flush(v_flush), .bus(bus3.slave), .drop_err(drop3), .idle(idle3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per (instance, lane); index = inst*4 + lane.
  typedef logic [31:0] word_q_t [$];
  word_q_t mq [8];
  logic    mdrop [2];
  int      np [2];

  typedef struct {
    logic        valid;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        flush;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic        exp_idle;
    int          chk_lane;
    logic [31:0] exp_lane;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic model_ready(input int d);
    if (v_flush) return 1'b0;
    if (int'(v_sel) >= np[d]) return 1'b1;
    return mq[d*4 + int'(v_sel)].size() < DEPTH;
  endfunction

  task automatic check_output();
    for (int d = 0; d < 2; d++) begin
      logic [3:0]   exp_ov, got_ov;
      logic [127:0] exp_od, got_od;
      logic         exp_idle, got_idle, got_rdy, got_drop;
      exp_ov = '0; exp_od = '0; exp_idle = 1'b1;
      for (int i = 0; i < np[d]; i++) begin
        if (mq[d*4+i].size() > 0) begin
          exp_ov[i] = 1'b1;
          exp_od[i*32 +: 32] = mq[d*4+i][0];
          exp_idle = 1'b0;
        end
      end
      if (d == 0) begin
        got_ov = bus4.out_valid; got_od = bus4.out_data;
        got_idle = idle4; got_rdy = bus4.in_ready; got_drop = drop4;
      end else begin
        got_ov = {1'b0, bus3.out_valid}; got_od = {32'h0, bus3.out_data};
        got_idle = idle3; got_rdy = bus3.in_ready; got_drop = drop3;
      end
      chk($sformatf("model np%0d in_ready", np[d]), got_rdy, model_ready(d));
      chk($sformatf("model np%0d out_valid", np[d]), got_ov, exp_ov);
      chk($sformatf("model np%0d out_data", np[d]), got_od, exp_od);
      chk($sformatf("model np%0d idle", np[d]), got_idle, exp_idle);
      chk($sformatf("model np%0d drop_err", np[d]), got_drop, mdrop[d]);
    end
  endtask

  task automatic model_advance();
    for (int d = 0; d < 2; d++) begin
      logic rdy;
      rdy = model_ready(d);
      if (v_flush) begin
        for (int i = 0; i < 4; i++) mq[d*4+i].delete();
      end else begin
        for (int i = 0; i < np[d]; i++)
          if (v_ordy[i] && mq[d*4+i].size() > 0) void'(mq[d*4+i].pop_front());
        if (v_valid && rdy && int'(v_sel) < np[d]) mq[d*4 + int'(v_sel)].push_back(v_data);
      end
      mdrop[d] = v_valid && rdy && (int'(v_sel) >= np[d]);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) mq[k].delete();
    mdrop[0] = 1'b0;
    mdrop[1] = 1'b0;
  endtask

  task automatic finish_cycle();
    check_output();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic apply_stimulus(input logic valid, input logic [1:0] sel, input logic [31:0] data,
                                input logic [3:0] ordy, input logic flush);
    v_valid = valid; v_sel = sel; v_data = data; v_ordy = ordy; v_flush = flush;
  endtask

  function automatic vec_t mk(input logic valid, input logic [1:0] sel, input logic [31:0] data,
                              input logic [3:0] ordy, input logic flush, input logic rdy,
                              input logic [3:0] ov, input logic idl, input int lane,
                              input logic [31:0] lane_data);
    vec_t v;
    v.valid = valid; v.sel = sel; v.data = data; v.ordy = ordy; v.flush = flush;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_idle = idl; v.chk_lane = lane; v.exp_lane = lane_data;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    np[0] = 4;
    np[1] = 3;
    model_clear();

    // Routing, full/no-pass-through, and flush expectations worked out by hand for the 4-lane instance.
    vecs[0]  = mk(1, 0, 32'hA0, 4'b0000, 0, 1, 4'b0000, 1, -1, 0);
    vecs[1]  = mk(1, 1, 32'hA1, 4'b0000, 0, 1, 4'b0001, 0, -1, 0);
    vecs[2]  = mk(1, 2, 32'hA2, 4'b0000, 0, 1, 4'b0011, 0, -1, 0);
    vecs[3]  = mk(1, 3, 32'hA3, 4'b0000, 0, 1, 4'b0111, 0,  0, 32'hA0);
    vecs[4]  = mk(0, 0, 32'h0,  4'b0000, 0, 1, 4'b1111, 0,  2, 32'hA2);
    vecs[5]  = mk(0, 0, 32'h0,  4'b1111, 0, 1, 4'b1111, 0,  3, 32'hA3);
    vecs[6]  = mk(0, 0, 32'h0,  4'b0000, 0, 1, 4'b0000, 1,  1, 32'h0);
    vecs[7]  = mk(1, 2, 32'hB0, 4'b0000, 0, 1, 4'b0000, 1, -1, 0);
    vecs[8]  = mk(1, 2, 32'hB1, 4'b0000, 0, 1, 4'b0100, 0, -1, 0);
    vecs[9]  = mk(1, 2, 32'hB2, 4'b0000, 0, 1, 4'b0100, 0, -1, 0);
    vecs[10] = mk(1, 2, 32'hB3, 4'b0000, 0, 1, 4'b0100, 0, -1, 0);
    vecs[11] = mk(1, 2, 32'hB4, 4'b0000, 0, 0, 4'b0100, 0,  2, 32'hB0);
    vecs[12] = mk(1, 0, 32'hC0, 4'b0000, 0, 1, 4'b0100, 0, -1, 0);
    vecs[13] = mk(1, 2, 32'hB4, 4'b0100, 0, 0, 4'b0101, 0,  2, 32'hB0);
    vecs[14] = mk(1, 2, 32'hB4, 4'b0000, 0, 1, 4'b0101, 0,  2, 32'hB1);
    vecs[15] = mk(0, 0, 32'h0,  4'b0100, 0, 1, 4'b0101, 0,  2, 32'hB1);
    vecs[16] = mk(0, 0, 32'h0,  4'b0100, 0, 1, 4'b0101, 0,  2, 32'hB2);
    vecs[17] = mk(0, 0, 32'h0,  4'b0100, 0, 1, 4'b0101, 0,  2, 32'hB3);
    vecs[18] = mk(0, 0, 32'h0,  4'b0100, 0, 1, 4'b0101, 0,  2, 32'hB4);
    vecs[19] = mk(0, 0, 32'h0,  4'b0001, 0, 1, 4'b0001, 0,  0, 32'hC0);
    vecs[20] = mk(0, 0, 32'h0,  4'b0000, 0, 1, 4'b0000, 1,  2, 32'h0);
    vecs[21] = mk(1, 0, 32'hD0, 4'b0000, 0, 1, 4'b0000, 1, -1, 0);
    vecs[22] = mk(1, 3, 32'hD3, 4'b0000, 0, 1, 4'b0001, 0, -1, 0);
    vecs[23] = mk(1, 1, 32'hD1, 4'b0000, 1, 0, 4'b1001, 0,  3, 32'hD3);
    vecs[24] = mk(0, 0, 32'h0,  4'b0000, 0, 1, 4'b0000, 1,  1, 32'h0);

    apply_stimulus(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    chk("reset in_ready", bus4.in_ready, 1'b1);
    chk("reset out_valid", bus4.out_valid, 4'b0000);
    chk("reset out_data", bus4.out_data, 128'h0);
    chk("reset idle", idle4, 1'b1);
    chk("reset drop_err", drop4, 1'b0);

    for (int i = 0; i < 25; i++) begin
      apply_stimulus(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].ordy, vecs[i].flush);
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), bus4.in_ready, vecs[i].exp_rdy);
      chk($sformatf("vec%0d out_valid", i), bus4.out_valid, vecs[i].exp_ov);
      chk($sformatf("vec%0d idle", i), idle4, vecs[i].exp_idle);
      if (vecs[i].chk_lane >= 0)
        chk($sformatf("vec%0d lane%0d data", i, vecs[i].chk_lane),
            bus4.out_data[vecs[i].chk_lane*32 +: 32], vecs[i].exp_lane);
      finish_cycle();
    end

    // Same-lane push and pop in one cycle keeps lane 1 at two words.
    apply_stimulus(1, 1, 32'hE0, 4'b0000, 0); step();
    apply_stimulus(1, 1, 32'hE1, 4'b0000, 0); step();
    apply_stimulus(1, 1, 32'hE2, 4'b0010, 0);
    @(negedge clk);
    chk("concurrent in_ready", bus4.in_ready, 1'b1);
    chk("concurrent head", bus4.out_data[63:32], 32'hE0);
    finish_cycle();
    apply_stimulus(0, 1, 32'h0, 4'b0000, 0);
    @(negedge clk);
    chk("after concurrent head", bus4.out_data[63:32], 32'hE1);
    finish_cycle();
    apply_stimulus(1, 1, 32'hE3, 4'b0000, 0); step();
    apply_stimulus(1, 1, 32'hE4, 4'b0000, 0); step();
    apply_stimulus(1, 1, 32'hE5, 4'b0000, 0);
    @(negedge clk);
    chk("lane1 full after two more", bus4.in_ready, 1'b0);
    finish_cycle();

    // Stream through lane 1 long enough to wrap the pointers several times.
    for (int k = 0; k < 6 * DEPTH; k++) begin
      apply_stimulus(1, 1, 32'hF00 + k, 4'b0010, 0);
      step();
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      apply_stimulus(0, 0, 32'h0, 4'b1111, 0);
      step();
    end

    // Illegal select on the 3-lane instance: accepted, dropped, one-cycle error pulse.
    apply_stimulus(1, 3, 32'hDEAD, 4'b0000, 0);
    @(negedge clk);
    chk("np3 illegal in_ready", bus3.in_ready, 1'b1);
    finish_cycle();
    apply_stimulus(0, 0, 32'h0, 4'b0000, 0);
    @(negedge clk);
    chk("np3 drop_err pulse", drop3, 1'b1);
    chk("np3 no lane valid", bus3.out_valid, 3'b000);
    finish_cycle();
    @(negedge clk);
    chk("np3 drop_err cleared", drop3, 1'b0);
    finish_cycle();
    apply_stimulus(0, 0, 32'h0, 4'b1111, 0); step();

    // Reset in the middle of traffic, while the 3-lane drop pulse is high.
    apply_stimulus(1, 0, 32'h11, 4'b0000, 0); step();
    apply_stimulus(1, 3, 32'h22, 4'b0000, 0); step();
    apply_stimulus(0, 0, 32'h0, 4'b0000, 0);
    reset = 1'b1;
    #1;
    chk("midreset out_valid", bus4.out_valid, 4'b0000);
    chk("midreset idle", idle4, 1'b1);
    chk("midreset np3 drop_err", drop3, 1'b0);
    chk("midreset np3 out_valid", bus3.out_valid, 3'b000);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset in_ready", bus4.in_ready, 1'b1);
    step();

    // Randomized traffic against the queue model, including illegal selects and flushes.
    for (int k = 0; k < 600; k++) begin
      logic [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 9) < 4);
      apply_stimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom, r,
                     ($urandom_range(0, 39) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
